// File: rtl/fop_pkg.sv
// Shared types and defaults for the fop phase sequencer.
// PAUSE is only reachable when FOP_SEQ_STEP_EN is defined.
package fop_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int FETCH_TMO_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_OPERATE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4,
    ST_PAUSE     = 3'd5
  } fop_state_e;

endpackage

// File: rtl/fop_seq_timer.sv
// FETCH watchdog: counts consecutive FETCH cycles, flags expiry
// on the TMO-th cycle so the FSM leaves FETCH after exactly TMO.
module fop_seq_timer #(
  parameter int TMO = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TMO + 1);
  localparam logic [W-1:0] LAST = W'(TMO - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fop_seq.sv
// fop phase sequencer: IDLE/FETCH/OPERATE/WRITEBACK/HALT.
// Define FOP_SEQ_STEP_EN for single-step debug (PAUSE state).
module fop_seq
  import fop_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FETCH_TMO = FETCH_TMO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             instr_valid,
  input  logic             instr_halt,
  input  logic             op_busy,
`ifdef FOP_SEQ_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             fetch_en,
  output logic             op_en,
  output logic             wb_en,
  output logic             pc_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fop_state_e       state_q, state_d;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_exp;

  fop_seq_timer #(
    .TMO (FETCH_TMO)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != ST_FETCH),
    .en      (state_q == ST_FETCH),
    .expired (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          halt_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        halt_d = halt_q | halt_req;
        // a valid instruction beats a timeout in the same cycle
        if (instr_valid) begin
          if (instr_halt) begin
            state_d = ST_HALT;
            halt_d  = 1'b0;
          end else begin
            state_d = ST_OPERATE;
          end
        end else if (tmo_exp) begin
          state_d = ST_HALT;
          halt_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      ST_OPERATE: begin
        halt_d = halt_q | halt_req;
        if (!op_busy) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (halt_q || halt_req) begin
          state_d = ST_HALT;
          halt_d  = 1'b0;
        end else begin
`ifdef FOP_SEQ_STEP_EN
          state_d = step_mode ? ST_PAUSE : ST_FETCH;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef FOP_SEQ_STEP_EN
      ST_PAUSE: begin
        if (halt_req) begin
          state_d = ST_HALT;
          halt_d  = 1'b0;
        end else if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        halt_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_en    = (state_q == ST_FETCH);
  assign op_en       = (state_q == ST_OPERATE);
  assign wb_en       = (state_q == ST_WRITEBACK);
  assign pc_inc      = (state_q == ST_WRITEBACK);
  assign done        = (state_q == ST_HALT);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign err         = err_q;
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fop_seq.sv
// Directed bench for fop_seq; a second CNT_W=2 copy
// exercises counter saturation on the same stimulus.
module tb_fop_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic halt_req = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_halt = 1'b0;
  logic op_busy = 1'b0;
`ifdef FOP_SEQ_STEP_EN
  logic step_mode = 1'b0;
  logic step = 1'b0;
`endif

  logic        fetch_en, op_en, wb_en, pc_inc;
  logic        busy, done, err;
  logic [15:0] instr_count;
  logic [2:0]  state;

  logic        s_fetch_en, s_op_en, s_wb_en, s_pc_inc;
  logic        s_busy, s_done, s_err;
  logic [1:0]  s_count;
  logic [2:0]  s_state;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FET  = 3'd1;
  localparam logic [2:0] OPR  = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] HLT  = 3'd4;

  always #5 clk = ~clk;

  fop_seq u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .instr_valid (instr_valid),
    .instr_halt  (instr_halt),
    .op_busy     (op_busy),
`ifdef FOP_SEQ_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .fetch_en    (fetch_en),
    .op_en       (op_en),
    .wb_en       (wb_en),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count),
    .state       (state)
  );

  fop_seq #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .instr_valid (instr_valid),
    .instr_halt  (instr_halt),
    .op_busy     (op_busy),
`ifdef FOP_SEQ_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .fetch_en    (s_fetch_en),
    .op_en       (s_op_en),
    .wb_en       (s_wb_en),
    .pc_inc      (s_pc_inc),
    .busy        (s_busy),
    .done        (s_done),
    .err         (s_err),
    .instr_count (s_count),
    .state       (s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] n_en();
    return 32'(fetch_en) + 32'(op_en) + 32'(wb_en);
  endfunction

  initial begin
    int nop, npc, nf, guard;
    logic [2:0] exp_st;

    // reset held with start asserted: must stay IDLE
    start = 1'b1;
    instr_valid = 1'b1;
    #12;
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_en", n_en(), 0);
    chk("rst_flags", {busy, done, err, pc_inc}, 0);
    chk("rst_count", 32'(instr_count), 0);

    // free-running back-to-back instructions
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      case ((k - 1) % 3)
        0:       exp_st = FET;
        1:       exp_st = OPR;
        default: exp_st = WB;
      endcase
      chk($sformatf("run_st%0d", k), 32'(state), 32'(exp_st));
      chk($sformatf("run_1hot%0d", k), n_en(), 1);
    end
    chk("run_count", 32'(instr_count), 5);
    chk("sat_count", 32'(s_count), 3);
    start = 1'b0;

    // multi-cycle operate
    op_busy = 1'b1;
    nop = 0;
    npc = 0;
    repeat (5) begin
      tick();
      nop += int'(op_en);
      npc += int'(pc_inc);
    end
    op_busy = 1'b0;
    tick();
    chk("busy_wb", 32'(state), 32'(WB));
    npc += int'(pc_inc);
    tick();
    npc += int'(pc_inc);
    chk("busy_fetch", 32'(state), 32'(FET));
    chk("busy_op_en", 32'(nop), 5);
    chk("busy_pc_inc", 32'(npc), 1);
    chk("busy_count", 32'(instr_count), 6);

    // halt request mid-operate retires the instruction first
    op_busy = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    op_busy = 1'b0;
    tick();
    chk("hreq_wb", 32'(state), 32'(WB));
    tick();
    chk("hreq_state", 32'(state), 32'(HLT));
    chk("hreq_done", {busy, done}, 2'b01);
    chk("hreq_count", 32'(instr_count), 7);
    halt_req = 1'b1;
    tick();
    chk("hreq_ign", 32'(state), 32'(HLT));
    halt_req = 1'b0;

    // fetch timeout
    instr_valid = 1'b0;
    start = 1'b1;
    tick();
    chk("tmo_fetch", 32'(state), 32'(FET));
    chk("tmo_clr", {err, instr_count}, 0);
    start = 1'b0;
    nf = 1;
    guard = 0;
    while (state == FET && guard < 20) begin
      tick();
      guard++;
      if (state == FET) nf++;
    end
    chk("tmo_cycles", 32'(nf), 8);
    chk("tmo_state", 32'(state), 32'(HLT));
    chk("tmo_err", {err, done}, 2'b11);

    // restart clears err
    instr_valid = 1'b1;
    start = 1'b1;
    tick();
    chk("rs_err", {err, instr_count}, 0);
    start = 1'b0;
    repeat (3) tick();
    chk("rs_fetch", 32'(state), 32'(FET));
    chk("rs_count", 32'(instr_count), 1);

    // valid arriving on the expiry cycle wins
    instr_valid = 1'b0;
    repeat (7) tick();
    chk("race_fetch", 32'(state), 32'(FET));
    instr_valid = 1'b1;
    tick();
    chk("race_op", 32'(state), 32'(OPR));
    chk("race_err", 32'(err), 0);
    repeat (2) tick();
    chk("race_count", 32'(instr_count), 2);

    // halt opcode together with halt_req
    instr_halt = 1'b1;
    halt_req = 1'b1;
    tick();
    chk("ih_state", 32'(state), 32'(HLT));
    chk("ih_count", 32'(instr_count), 2);
    instr_halt = 1'b0;
    halt_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ih_latch", 32'(state), 32'(FET));
    chk("ih_recount", 32'(instr_count), 1);

    // asynchronous reset mid-operate
    op_busy = 1'b1;
    tick();
    chk("ar_op", 32'(op_en), 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'(IDLE));
    chk("ar_en", n_en(), 0);
    chk("ar_flags", {busy, done, err, pc_inc}, 0);
    chk("ar_count", 32'(instr_count), 0);
    op_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ar_idle", 32'(state), 32'(IDLE));

`ifdef FOP_SEQ_STEP_EN
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("st_pause", 32'(state), 32'd5);
    chk("st_busy", 32'(busy), 1);
    chk("st_cnt1", 32'(instr_count), 1);
    tick();
    chk("st_hold", 32'(state), 32'd5);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("st_fetch", 32'(state), 32'(FET));
    repeat (3) tick();
    chk("st_pause2", 32'(state), 32'd5);
    chk("st_cnt2", 32'(instr_count), 2);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("st_halt", 32'(state), 32'(HLT));
    step_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
